// File: rtl/timer_pkg.sv
// Shared register map, CFG bit positions and channel state type for the multi-channel timer.
package timer_pkg;

   localparam int unsigned MAX_CH = 8;

   localparam logic [7:0] OFS_PRESCALE  = 8'h00;
   localparam logic [7:0] OFS_STATUS    = 8'h04;
   localparam logic [7:0] OFS_IRQ_EN    = 8'h08;
   localparam logic [7:0] OFS_CH_BASE   = 8'h10;
   localparam logic [7:0] OFS_CH_STRIDE = 8'h10;

   localparam logic [3:0] OFS_CFG    = 4'h0;
   localparam logic [3:0] OFS_RELOAD = 4'h4;
   localparam logic [3:0] OFS_COUNT  = 4'h8;
   localparam logic [3:0] OFS_CMD    = 4'hC;

   localparam int unsigned CFG_EN       = 0;
   localparam int unsigned CFG_PERIODIC = 1;
   localparam int unsigned CFG_USE_PRE  = 2;
   localparam int unsigned CFG_W        = 3;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   // Byte offset of channel ch's register block.
   function automatic logic [7:0] ch_base(input int unsigned ch);
      return OFS_CH_BASE + 8'(ch) * OFS_CH_STRIDE;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CFG/RELOAD/COUNT registers and the IDLE/RUN control.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned RELOAD_RST = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic             reload_we,
   input  logic             cmd_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pre_tick,
   output logic [CFG_W-1:0] cfg,
   output logic [WIDTH-1:0] reload,
   output logic [WIDTH-1:0] count,
   output logic             timeout_c
);

   ch_state_e        state_q, state_d;
   logic             periodic_q, periodic_d;
   logic             use_pre_q, use_pre_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tick;
   logic             cmd_load;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CH_IDLE;
         periodic_q <= 1'b0;
         use_pre_q  <= 1'b0;
         reload_q   <= WIDTH'(RELOAD_RST);
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         periodic_q <= periodic_d;
         use_pre_q  <= use_pre_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
      end
   end

   // Next state: tick/timeout first, then software CFG write, then forced load wins on COUNT.
   always_comb begin
      state_d    = state_q;
      periodic_d = periodic_q;
      use_pre_d  = use_pre_q;
      reload_d   = reload_q;
      count_d    = count_q;
      timeout_c  = 1'b0;
      tick       = (state_q == CH_RUN) && (use_pre_q ? pre_tick : 1'b1);
      cmd_load   = cmd_we && wdata[0];

      if (tick && !cmd_load) begin
         if (count_q == '0) begin
            timeout_c = 1'b1;
            if (periodic_q) begin
               count_d = reload_q;
            end else begin
               state_d = CH_IDLE;
            end
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end

      if (cfg_we) begin
         periodic_d = wdata[CFG_PERIODIC];
         use_pre_d  = wdata[CFG_USE_PRE];
         if (wdata[CFG_EN]) begin
            state_d = CH_RUN;
            if (state_q == CH_IDLE) begin
               count_d = reload_q;
            end
         end else begin
            state_d = CH_IDLE;
         end
      end

      if (cmd_load) begin
         count_d = reload_q;
      end

      if (reload_we) begin
         reload_d = wdata;
      end
   end

   assign cfg    = {use_pre_q, periodic_q, (state_q == CH_RUN)};
   assign reload = reload_q;
   assign count  = count_q;

endmodule

// File: rtl/multi_timer_ip.sv
// Multi-channel bus timer: register decode, shared prescaler, STATUS/IRQ_EN and read mux.
module multi_timer_ip
   import timer_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned PRE_W      = 16,
   parameter int unsigned RELOAD_RST = 50
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              bus_sel,
   input  logic              bus_wr,
   input  logic [31:0]       bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              timer_irq,
   output logic [NUM_CH-1:0] ch_pulse
);

   logic [PRE_W-1:0]  prescale_q, prescale_d;
   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic [NUM_CH-1:0] status_q, status_d;
   logic [NUM_CH-1:0] irq_en_q, irq_en_d;
   logic [NUM_CH-1:0] ch_pulse_q, ch_pulse_d;
   logic              timer_irq_q, timer_irq_d;

   logic [7:0]        addr8;
   logic [3:0]        ofs;
   logic              wr_en;
   logic              pre_we, status_we, irq_en_we;
   logic              pre_tick_c;
   logic [7:0]        base;
   logic [NUM_CH-1:0] ch_sel;
   logic [NUM_CH-1:0] cfg_we, reload_we, cmd_we;
   logic [NUM_CH-1:0] timeout_vec;
   logic [NUM_CH-1:0][CFG_W-1:0] cfg_vec;
   logic [NUM_CH-1:0][WIDTH-1:0] reload_vec;
   logic [NUM_CH-1:0][WIDTH-1:0] count_vec;
   logic              unused_bus;

   assign addr8      = bus_addr[7:0];
   assign ofs        = addr8[3:0];
   assign wr_en      = bus_sel && bus_wr;
   assign pre_we     = wr_en && (addr8 == OFS_PRESCALE);
   assign status_we  = wr_en && (addr8 == OFS_STATUS);
   assign irq_en_we  = wr_en && (addr8 == OFS_IRQ_EN);
   assign unused_bus = ^{bus_addr[31:8], bus_wdata};

   // Channel slot decode from the upper address nibble.
   always_comb begin
      ch_sel = '0;
      base   = '0;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
         if (i < NUM_CH) begin
            base = ch_base(i);
            if (addr8[7:4] == base[7:4]) begin
               ch_sel[i] = 1'b1;
            end
         end
      end
   end

   assign cfg_we    = ch_sel & {NUM_CH{wr_en && (ofs == OFS_CFG)}};
   assign reload_we = ch_sel & {NUM_CH{wr_en && (ofs == OFS_RELOAD)}};
   assign cmd_we    = ch_sel & {NUM_CH{wr_en && (ofs == OFS_CMD)}};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_channel #(
         .WIDTH      (WIDTH),
         .RELOAD_RST (RELOAD_RST)
      ) u_ch (
         .clk       (sys_clk),
         .rst       (rst),
         .cfg_we    (cfg_we[g]),
         .reload_we (reload_we[g]),
         .cmd_we    (cmd_we[g]),
         .wdata     (bus_wdata[WIDTH-1:0]),
         .pre_tick  (pre_tick_c),
         .cfg       (cfg_vec[g]),
         .reload    (reload_vec[g]),
         .count     (count_vec[g]),
         .timeout_c (timeout_vec[g])
      );
   end

   // Global registers and prescaler next-state.
   always_comb begin
      prescale_d  = prescale_q;
      irq_en_d    = irq_en_q;
      pre_tick_c  = (pre_cnt_q == prescale_q);
      pre_cnt_d   = pre_cnt_q + PRE_W'(1);
      if (pre_tick_c || pre_we) begin
         pre_cnt_d = '0;
      end
      if (pre_we) begin
         prescale_d = bus_wdata[PRE_W-1:0];
      end
      if (irq_en_we) begin
         irq_en_d = bus_wdata[NUM_CH-1:0];
      end
      // A hardware timeout on the same bit as a W1C keeps the bit set.
      status_d    = status_q | timeout_vec;
      if (status_we) begin
         status_d = (status_q & ~bus_wdata[NUM_CH-1:0]) | timeout_vec;
      end
      ch_pulse_d  = timeout_vec;
      timer_irq_d = |(status_q & irq_en_q);
   end

   // Global register file with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         prescale_q  <= '0;
         pre_cnt_q   <= '0;
         status_q    <= '0;
         irq_en_q    <= '0;
         ch_pulse_q  <= '0;
         timer_irq_q <= 1'b0;
      end else begin
         prescale_q  <= prescale_d;
         pre_cnt_q   <= pre_cnt_d;
         status_q    <= status_d;
         irq_en_q    <= irq_en_d;
         ch_pulse_q  <= ch_pulse_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   // Combinational read mux; unmapped, absent channels and CMD read as zero.
   always_comb begin
      bus_rdata = '0;
      if (addr8 == OFS_PRESCALE) begin
         bus_rdata = 32'(prescale_q);
      end else if (addr8 == OFS_STATUS) begin
         bus_rdata = 32'(status_q);
      end else if (addr8 == OFS_IRQ_EN) begin
         bus_rdata = 32'(irq_en_q);
      end
      for (int unsigned i = 0; i < MAX_CH; i++) begin
         if (i < NUM_CH && ch_sel[i]) begin
            case (ofs)
               OFS_CFG:    bus_rdata = 32'(cfg_vec[i]);
               OFS_RELOAD: bus_rdata = 32'(reload_vec[i]);
               OFS_COUNT:  bus_rdata = 32'(count_vec[i]);
               default:    bus_rdata = '0;
            endcase
         end
      end
   end

   assign timer_irq = timer_irq_q;
   assign ch_pulse  = ch_pulse_q;

endmodule

// File: doc/multi_timer_ip.md
Name: multi_timer_ip

Overview:
- Parametrised successor to the single-channel bus timer.
- Provides NUM_CH independent down-counting channels of WIDTH bits, sharing a global prescaler.
- Each channel has one-shot (auto-disable) or periodic mode, sticky W1C status and an interrupt enable.
- Sits on the same simple memory-mapped peripheral bus as the existing timer and drives one combined level interrupt to the core plus per-channel pulses.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- WIDTH, 32, counter/reload width in bits (8..32).
- PRE_W, 16, prescaler width in bits (1..32).
- RELOAD_RST, 50, reset value of every channel's RELOAD.

Ports:
- sys_clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- bus_sel  in  1  peripheral select.
- bus_wr  in  1  write strobe; a write happens on any cycle with bus_sel&&bus_wr.
- bus_addr  in  32  byte address; only [7:0] decoded.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  combinational read data for bus_addr.
- timer_irq  out  1  registered level: |(STATUS & IRQ_EN).
- ch_pulse  out  NUM_CH  one-cycle timeout pulse per channel.

Behaviour:
- Interface decision: one clock (sys_clk); reset (rst) is synchronous and active-high.
- Register map:
  - Global: 0x00 PRESCALE (RW, PRE_W bits); 0x04 STATUS (bit ch sticky timeout, W1C); 0x08 IRQ_EN (RW, NUM_CH bits).
  - Channel ch, base B=0x10+0x10*ch: B+0 CFG (bit0 en, bit1 periodic, bit2 use_prescale); B+4 RELOAD (RW); B+8 COUNT (RO); B+C CMD (WO, bit0 = force load COUNT<=RELOAD, reads 0).
- Reset values: all registers 0, except RELOAD = RELOAD_RST and PRESCALE = 0. bus_rdata follows its decode; timer_irq=0; ch_pulse=0.
- Reads:
  - Zero-extended to 32 bits.
  - Unmapped addresses, channels >= NUM_CH, and CMD all read 0.
  - Writes are truncated to the field width; writes to unmapped or RO locations are ignored.
- Prescaler:
  - Free-running pre_cnt, cleared by reset.
  - pre_tick=1 when pre_cnt==PRESCALE, and pre_cnt then wraps to 0; otherwise pre_cnt increments.
  - PRESCALE=0 gives pre_tick every cycle.
  - Writing PRESCALE also clears pre_cnt.
- Channel tick = en && (use_prescale ? pre_tick : 1).
- Channel states: IDLE (en=0, COUNT frozen) and RUN (en=1).
  - IDLE->RUN: a CFG write with en=1 while en=0 also loads COUNT<=RELOAD at the same edge.
  - RUN->IDLE: CFG write with en=0, or one-shot timeout.
- On tick in RUN:
  - COUNT>0: COUNT decrements.
  - COUNT==0: timeout. STATUS[ch]<=1 and ch_pulse[ch]=1 for one cycle.
    - Periodic: COUNT<=RELOAD.
    - One-shot: COUNT stays 0 and en<=0 (auto-disable, visible in CFG).
- Period is (RELOAD+1) ticks. RELOAD=0 periodic times out on every tick.
- RELOAD written while running takes effect at the next load only.
- CMD load: COUNT<=RELOAD at that edge and takes priority over that cycle's decrement/timeout.
- Simultaneous STATUS W1C and hardware timeout on the same bit in one cycle: the set wins (bit stays 1).
- timer_irq is registered from the post-update STATUS&IRQ_EN, so it asserts one cycle after the STATUS bit sets.
- Clearing STATUS or IRQ_EN deasserts timer_irq on the following edge.
- Reset mid-count: all state returns to reset values at the next edge; no pulse is emitted.

Decomposition:
- Shared package timer_pkg holds:
  - Register offsets (PRESCALE, STATUS, IRQ_EN, CH_BASE, CH_STRIDE, CFG, RELOAD, COUNT, CMD).
  - CFG bit indices.
  - MAX_CH=8.
- Sub-module timer_channel holds WIDTH-bit COUNT/RELOAD/CFG, takes decoded write enables, pre_tick and a W1C-less timeout output, and is instantiated NUM_CH times by generate.
- The top level holds the bus decode, prescaler, STATUS/IRQ_EN and the read mux.

Test Plan:
1. Reset, read every register -> RELOAD=50 in each channel, all others 0, timer_irq=0.
2. ch0 RELOAD=3, IRQ_EN=1, CFG=0x3, PRESCALE=0 -> ch_pulse[0] on the 4th edge after the enable edge and every 4 cycles after; STATUS=0x1; timer_irq high one cycle later.
3. ch1 RELOAD=2 one-shot, CFG=0x1 -> single pulse after 3 cycles; CFG reads 0x0; COUNT stays 0; no further pulses.
4. PRESCALE=4, ch2 RELOAD=1, CFG=0x7 -> pulse every 10 cycles. Change RELOAD to 5 mid-run -> current period unchanged, next period 30 cycles.
5. Write STATUS=0x1 on the exact cycle ch0 times out again -> STATUS[0] remains 1. W1C a cycle later -> STATUS=0 and timer_irq low the next edge.
6. Assert rst mid-count with ch3 COUNT=7 -> all registers at reset values next cycle; ch_pulse stays 0; COUNT=0.
